// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, runs the imem req/ack handshake,
// presents fetched words to decode and applies execute redirects.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h8000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        br_taken,
  input  logic [31:0] pc_branch,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] pc_default_out
);

  typedef enum logic [1:0] {IDLE, FETCH, VALID, DROP} state_t;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc_dflt;
  } out_t;

  state_t      state, state_nxt;
  out_t        out_q, out_nxt;
  logic [31:0] fetch_pc, fetch_pc_nxt;
  logic [31:0] saved_tgt, saved_tgt_nxt;
  logic [31:0] tgt, drop_tgt, pc_inc;
  logic        ack_v;

  assign tgt      = {pc_branch[31:2], 2'b00};
  assign pc_inc   = fetch_pc + PC_STEP;
  // A stray ack with no request in flight carries no data for us.
  assign ack_v    = imem_ack & out_q.req;
  assign drop_tgt = br_taken ? tgt : saved_tgt;

  always_comb begin
    state_nxt     = state;
    out_nxt       = out_q;
    fetch_pc_nxt  = fetch_pc;
    saved_tgt_nxt = saved_tgt;
    case (state)
      IDLE: begin
        state_nxt   = FETCH;
        out_nxt.req = 1'b1;
        if (br_taken) begin
          fetch_pc_nxt = tgt;
          out_nxt.addr = tgt;
        end else begin
          out_nxt.addr = fetch_pc;
        end
      end
      FETCH: begin
        // imem_addr == fetch_pc throughout FETCH; request held until ack.
        if (ack_v) begin
          if (br_taken) begin
            fetch_pc_nxt = tgt;
            out_nxt.addr = tgt;
          end else begin
            out_nxt.inst    = imem_rdata;
            out_nxt.pc      = fetch_pc;
            out_nxt.pc_dflt = pc_inc;
            out_nxt.vld     = 1'b1;
            out_nxt.req     = 1'b0;
            fetch_pc_nxt    = pc_inc;
            state_nxt       = VALID;
          end
        end else if (br_taken) begin
          saved_tgt_nxt = tgt;
          state_nxt     = DROP;
        end
      end
      VALID: begin
        if (br_taken) begin
          out_nxt.vld  = 1'b0;
          out_nxt.req  = 1'b1;
          out_nxt.addr = tgt;
          fetch_pc_nxt = tgt;
          state_nxt    = FETCH;
        end else if (!stall) begin
          out_nxt.vld  = 1'b0;
          out_nxt.req  = 1'b1;
          out_nxt.addr = fetch_pc;
          state_nxt    = FETCH;
        end
      end
      DROP: begin
        // Stale request still in flight: wait out its ack, latest target wins.
        if (ack_v) begin
          fetch_pc_nxt = drop_tgt;
          out_nxt.addr = drop_tgt;
          state_nxt    = FETCH;
        end else if (br_taken) begin
          saved_tgt_nxt = tgt;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      fetch_pc      <= RESET_PC;
      saved_tgt     <= '0;
      out_q.req     <= 1'b0;
      out_q.addr    <= RESET_PC;
      out_q.vld     <= 1'b0;
      out_q.inst    <= '0;
      out_q.pc      <= RESET_PC;
      out_q.pc_dflt <= RESET_PC + PC_STEP;
    end else begin
      state     <= state_nxt;
      fetch_pc  <= fetch_pc_nxt;
      saved_tgt <= saved_tgt_nxt;
      out_q     <= out_nxt;
    end
  end

  assign imem_req       = out_q.req;
  assign imem_addr      = out_q.addr;
  assign inst_valid     = out_q.vld;
  assign inst           = out_q.inst;
  assign inst_pc        = out_q.pc;
  assign pc_default_out = out_q.pc_dflt;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed table-driven bench for fetch_ctrl plus hand sequences for reset cases.
module tb_fetch_ctrl;

  logic        clk, rst;
  logic        br_taken, stall, imem_ack;
  logic [31:0] pc_branch, imem_rdata;
  logic        imem_req, inst_valid;
  logic [31:0] imem_addr, inst, inst_pc, pc_default_out;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_ctrl dut (
    .clk(clk), .rst(rst), .br_taken(br_taken), .pc_branch(pc_branch),
    .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst_valid(inst_valid),
    .inst(inst), .inst_pc(inst_pc), .pc_default_out(pc_default_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        br;
    logic [31:0] tgt;
    logic        stall;
    logic        ack;
    logic [31:0] rdata;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] inst;
    logic [31:0] ipc;
    logic [31:0] pdef;
  } vec_t;

  vec_t vecs[30];

  function automatic vec_t mk(logic br, logic [31:0] tgt, logic st, logic ack,
                              logic [31:0] rd, logic req, logic [31:0] addr,
                              logic vld, logic [31:0] in, logic [31:0] ipc,
                              logic [31:0] pdef);
    vec_t v;
    v.br = br; v.tgt = tgt; v.stall = st; v.ack = ack; v.rdata = rd;
    v.req = req; v.addr = addr; v.vld = vld; v.inst = in; v.ipc = ipc; v.pdef = pdef;
    return v;
  endfunction

  task automatic check(string name, logic req, logic [31:0] addr, logic vld,
                       logic [31:0] in, logic [31:0] ipc, logic [31:0] pdef);
    n_tests++;
    if (imem_req !== req || imem_addr !== addr || inst_valid !== vld ||
        inst !== in || inst_pc !== ipc || pc_default_out !== pdef) begin
      n_fail++;
      $display("FAIL %s: got req=%0b addr=%h vld=%0b inst=%h pc=%h pdef=%h, expected req=%0b addr=%h vld=%0b inst=%h pc=%h pdef=%h",
               name, imem_req, imem_addr, inst_valid, inst, inst_pc, pc_default_out,
               req, addr, vld, in, ipc, pdef);
    end
  endtask

  task automatic step(vec_t v, string name);
    br_taken = v.br; pc_branch = v.tgt; stall = v.stall;
    imem_ack = v.ack; imem_rdata = v.rdata;
    @(posedge clk);
    #1;
    check(name, v.req, v.addr, v.vld, v.inst, v.ipc, v.pdef);
  endtask

  initial begin
    // sequential fetch with a 5-cycle stall after the first instruction
    vecs[0]  = mk(0, 0, 0, 0, 0,            1, 32'h8000, 0, 0,     32'h8000, 32'h8004);
    vecs[1]  = mk(0, 0, 0, 1, 32'h11,       0, 32'h8000, 1, 32'h11, 32'h8000, 32'h8004);
    for (int i = 2; i <= 6; i++)
      vecs[i] = mk(0, 0, 1, 0, 0,           0, 32'h8000, 1, 32'h11, 32'h8000, 32'h8004);
    vecs[7]  = mk(0, 0, 0, 0, 0,            1, 32'h8004, 0, 32'h11, 32'h8000, 32'h8004);
    vecs[8]  = mk(0, 0, 0, 1, 32'h22,       0, 32'h8004, 1, 32'h22, 32'h8004, 32'h8008);
    vecs[9]  = mk(0, 0, 0, 0, 0,            1, 32'h8008, 0, 32'h22, 32'h8004, 32'h8008);
    vecs[10] = mk(0, 0, 0, 1, 32'h33,       0, 32'h8008, 1, 32'h33, 32'h8008, 32'h800C);
    // redirect in VALID beats stall, target low bits masked
    vecs[11] = mk(1, 32'h9003, 1, 0, 0,     1, 32'h9000, 0, 32'h33, 32'h8008, 32'h800C);
    // redirects while outstanding, ack after 3 wait cycles
    vecs[12] = mk(1, 32'hA000, 0, 0, 0,     1, 32'h9000, 0, 32'h33, 32'h8008, 32'h800C);
    vecs[13] = mk(1, 32'hB000, 0, 0, 0,     1, 32'h9000, 0, 32'h33, 32'h8008, 32'h800C);
    vecs[14] = mk(0, 0, 0, 0, 0,            1, 32'h9000, 0, 32'h33, 32'h8008, 32'h800C);
    vecs[15] = mk(0, 0, 0, 1, 32'hDEAD,     1, 32'hB000, 0, 32'h33, 32'h8008, 32'h800C);
    vecs[16] = mk(0, 0, 0, 1, 32'h44,       0, 32'hB000, 1, 32'h44, 32'hB000, 32'hB004);
    vecs[17] = mk(0, 0, 0, 0, 0,            1, 32'hB004, 0, 32'h44, 32'hB000, 32'hB004);
    // redirect coincident with ack in FETCH
    vecs[18] = mk(1, 32'hC000, 0, 1, 32'h55, 1, 32'hC000, 0, 32'h44, 32'hB000, 32'hB004);
    vecs[19] = mk(0, 0, 0, 1, 32'h66,       0, 32'hC000, 1, 32'h66, 32'hC000, 32'hC004);
    // wraparound
    vecs[20] = mk(1, 32'hFFFFFFFC, 0, 0, 0, 1, 32'hFFFFFFFC, 0, 32'h66, 32'hC000, 32'hC004);
    vecs[21] = mk(0, 0, 0, 1, 32'h77,       0, 32'hFFFFFFFC, 1, 32'h77, 32'hFFFFFFFC, 32'h0);
    vecs[22] = mk(0, 0, 0, 0, 0,            1, 32'h0, 0, 32'h77, 32'hFFFFFFFC, 32'h0);
    vecs[23] = mk(0, 0, 0, 1, 32'h88,       0, 32'h0, 1, 32'h88, 32'h0, 32'h4);
    // ack with no request outstanding is ignored
    vecs[24] = mk(0, 0, 1, 1, 32'h99,       0, 32'h0, 1, 32'h88, 32'h0, 32'h4);
    vecs[25] = mk(0, 0, 0, 0, 0,            1, 32'h4, 0, 32'h88, 32'h0, 32'h4);
    // DROP exit with a branch on the ack cycle takes the new target
    vecs[26] = mk(1, 32'hD000, 0, 0, 0,     1, 32'h4, 0, 32'h88, 32'h0, 32'h4);
    vecs[27] = mk(1, 32'hE004, 0, 1, 32'h12345678, 1, 32'hE004, 0, 32'h88, 32'h0, 32'h4);
    vecs[28] = mk(0, 0, 0, 1, 32'hAA,       0, 32'hE004, 1, 32'hAA, 32'hE004, 32'hE008);
    vecs[29] = mk(0, 0, 0, 0, 0,            1, 32'hE008, 0, 32'hAA, 32'hE004, 32'hE008);

    rst = 1'b0; br_taken = 0; pc_branch = 0; stall = 0; imem_ack = 0; imem_rdata = 0;
    #12;
    check("reset_values", 0, 32'h8000, 0, 0, 32'h8000, 32'h8004);
    rst = 1'b1;

    for (int i = 0; i < 30; i++) step(vecs[i], $sformatf("vec%0d", i));

    // asynchronous reset while a request is outstanding
    #2 rst = 1'b0;
    #1 check("async_reset", 0, 32'h8000, 0, 0, 32'h8000, 32'h8004);
    @(negedge clk); rst = 1'b1;
    step(mk(0, 0, 0, 0, 0, 1, 32'h8000, 0, 0, 32'h8000, 32'h8004), "refetch_after_reset");

    // branch during the IDLE cycle
    #2 rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    step(mk(1, 32'h1236, 0, 0, 0, 1, 32'h1234, 0, 0, 32'h8000, 32'h8004), "idle_branch");
    step(mk(0, 0, 0, 1, 32'hBB, 0, 32'h1234, 1, 32'hBB, 32'h1234, 32'h1238), "idle_branch_data");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Instruction-fetch sequencer that owns the program counter and drives the instruction-memory request/acknowledge handshake. It delivers fetched instructions to decode with a valid/stall handshake. It applies branch redirects from execute, including redirects that arrive while a memory request is outstanding. It sits between the PC path, instruction memory and the decode stage.

Parameters:
RESET_PC, 32'h8000, fetch address loaded on reset.
PC_STEP, 32'd4, sequential PC increment.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous active-low reset.
br_taken  input  1  redirect request from execute.
pc_branch  input  32  redirect target; bits [1:0] are forced to 0 internally.
stall  input  1  decode cannot accept the presented instruction.
imem_req  output  1  instruction-memory request, registered.
imem_addr  output  32  request address, registered.
imem_ack  input  1  one-cycle acknowledge; imem_rdata is valid in the same cycle.
imem_rdata  input  32  fetched instruction word.
inst_valid  output  1  inst/inst_pc presented to decode.
inst  output  32  fetched instruction.
inst_pc  output  32  address of inst.
pc_default_out  output  32  inst_pc + PC_STEP, modulo 2^32.

Behaviour:
- Clock and reset: single clock clk. rst is asynchronous and active-low.
- Reset values: state=IDLE, fetch_pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=RESET_PC, pc_default_out=RESET_PC+PC_STEP, saved_tgt=0.
- Reset asserted mid-operation aborts everything, including an outstanding request. The memory side must tolerate a dropped req.
- States: IDLE, FETCH, VALID, DROP. All outputs are registered.
- IDLE: lasts exactly one cycle after reset release, then goes to FETCH with imem_req=1 and imem_addr=fetch_pc.
  - br_taken in IDLE: fetch_pc<=target, then FETCH.
- FETCH: imem_req and imem_addr stay stable until imem_ack. A request is never withdrawn or changed before ack.
  - ack & !br_taken: inst<=imem_rdata, inst_pc<=fetch_pc, inst_valid<=1, fetch_pc<=fetch_pc+PC_STEP, imem_req<=0, go to VALID.
  - ack & br_taken: discard data, fetch_pc<=target, imem_addr<=target, imem_req stays 1, stay in FETCH.
  - !ack & br_taken: saved_tgt<=target, go to DROP.
  - ack may arrive in the first cycle req is high, giving 1-cycle memory latency.
- VALID: inst_valid=1, and inst/inst_pc are held while stall=1.
  - br_taken (priority over stall): inst_valid<=0, fetch_pc<=target, go to FETCH.
  - !stall & !br_taken: instruction consumed this cycle. inst_valid<=0, go to FETCH with addr=fetch_pc.
  - Throughput with zero-wait memory: one instruction every 2 cycles.
- DROP: imem_req stays high with the old address.
  - br_taken without ack: saved_tgt<=new target (latest wins).
  - ack: discard rdata, go to FETCH with addr = (br_taken this cycle ? new target : saved_tgt).
  - inst_valid stays 0 throughout DROP.
- Arithmetic: PC addition wraps modulo 2^32, so 32'hFFFFFFFC+4 = 0.
- imem_ack while imem_req=0 is ignored.
- pc_default_out is always inst_pc+PC_STEP and is updated with inst_pc.

Test Plan:
- Reset and sequential fetch: release rst, zero-wait ack returning 0x11,0x22,0x33. imem_addr sequence is 0x8000, 0x8004, 0x8008. inst_valid pulses with inst_pc matching each address. pc_default_out is 0x8004, 0x8008, 0x800C.
- Stall hold: stall=1 for 5 cycles in VALID. inst_valid, inst and inst_pc are unchanged and imem_req stays 0. On stall release the next fetch is 0x8004.
- Redirect in VALID: br_taken=1, pc_branch=0x9003 with stall=1. inst_valid drops next cycle and the next imem_addr is 0x9000.
- Redirect while outstanding:
  - Setup: ack delayed 3 cycles; br_taken to 0xA000 in wait cycle 1, then to 0xB000 in wait cycle 2.
  - Required: old address held until ack and returned data discarded (inst_valid never rises). The next request is 0xB000.
- Redirect coincident with ack: ack and br_taken(0xC000) in the same FETCH cycle. Data is dropped, imem_req stays high, and imem_addr is 0xC000 next cycle.
- Wrap and reset mid-request:
  - Branch to 0xFFFFFFFC: the fetch after it is at 0x0.
  - Assert rst while imem_req=1: imem_req=0 and inst_valid=0 immediately (asynchronous). After release, the first fetch is at 0x8000.
